// File: rtl/decoder_seq_pkg.sv
// Shared encodings for the sequencing instruction decoder: opcodes, ALU
// operation codes and FSM state encoding.
package decoder_seq_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LD  = 8'h01;
    localparam logic [7:0] OP_LDR = 8'h02;
    localparam logic [7:0] OP_ADD = 8'h03;
    localparam logic [7:0] OP_SUB = 8'h04;
    localparam logic [7:0] OP_INC = 8'h05;
    localparam logic [7:0] OP_DEC = 8'h06;
    localparam logic [7:0] OP_AND = 8'h07;
    localparam logic [7:0] OP_OR  = 8'h08;
    localparam logic [7:0] OP_XOR = 8'h09;
    localparam logic [7:0] OP_XNR = 8'h0A;
    localparam logic [7:0] OP_COM = 8'h0B;
    localparam logic [7:0] OP_CLR = 8'h0C;
    localparam logic [7:0] OP_FIL = 8'h0D;
    localparam logic [7:0] OP_PSH = 8'h0E;
    localparam logic [7:0] OP_POP = 8'h0F;
    localparam logic [7:0] OP_JMP = 8'h10;
    localparam logic [7:0] OP_JZ  = 8'h11;
    localparam logic [7:0] OP_JNZ = 8'h12;
    localparam logic [7:0] OP_JC  = 8'h13;
    localparam logic [7:0] OP_JNC = 8'h14;
    localparam logic [7:0] OP_CAL = 8'h15;
    localparam logic [7:0] OP_RTN = 8'h16;
    localparam logic [7:0] OP_WR  = 8'h17;
    localparam logic [7:0] OP_RD  = 8'h18;
    localparam logic [7:0] OP_CIS = 8'h19;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_INC = 3'd2,
        ALU_DEC = 3'd3,
        ALU_AND = 3'd4,
        ALU_OR  = 3'd5,
        ALU_XOR = 3'd6,
        ALU_XNR = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_HALT    = 2'd2
    } state_e;

    // Opcodes are allocated densely from zero, so anything above CIS is unknown.
    function automatic logic is_known_op(input logic [7:0] op);
        return (op <= OP_CIS);
    endfunction

    function automatic alu_op_e alu_op_of(input logic [7:0] op);
        alu_op_e res;
        case (op)
            OP_ADD:  res = ALU_ADD;
            OP_SUB:  res = ALU_SUB;
            OP_INC:  res = ALU_INC;
            OP_DEC:  res = ALU_DEC;
            OP_AND:  res = ALU_AND;
            OP_OR:   res = ALU_OR;
            OP_XOR:  res = ALU_XOR;
            OP_XNR:  res = ALU_XNR;
            default: res = ALU_SUB;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/decoder_seq_cond_eval.sv
// Jump-condition evaluation: decides whether a jump opcode is taken given
// the current zero and carry flags. Non-jump opcodes never report taken.
module dec_cond_eval
    import decoder_seq_pkg::*;
(
    input  logic [7:0] opcode_i,
    input  logic       flag_z_i,
    input  logic       flag_c_i,
    output logic       take_o
);

    always_comb begin
        take_o = 1'b0;
        case (opcode_i)
            OP_JMP:  take_o = 1'b1;
            OP_JZ:   take_o = flag_z_i;
            OP_JNZ:  take_o = ~flag_z_i;
            OP_JC:   take_o = flag_c_i;
            OP_JNC:  take_o = ~flag_c_i;
            default: take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/decoder_seq.sv
// Sequencing instruction decoder with multi-cycle RAM reads. Optional sticky
// stack-fault halt is enabled by defining DECODER_SEQ_FAULT_EN.
module decoder_seq
    import decoder_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 6,
    parameter int PC_W   = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic [8+2*DATA_W-1:0] instr_i,
    input  logic [PC_W-1:0]       pc_i,
    output logic                  jump_en_o,
    output logic [PC_W-1:0]       jump_addr_o,
    output logic                  reg_we_o,
    output logic [REG_AW-1:0]     reg_waddr_o,
    output logic [DATA_W-1:0]     reg_wdata_o,
    output logic [REG_AW-1:0]     reg_raddr_a_o,
    output logic [REG_AW-1:0]     reg_raddr_b_o,
    input  logic [DATA_W-1:0]     reg_rdata_a_i,
    input  logic [DATA_W-1:0]     reg_rdata_b_i,
    output logic [2:0]            alu_op_o,
    output logic [DATA_W-1:0]     alu_a_o,
    output logic [DATA_W-1:0]     alu_b_o,
    input  logic [DATA_W-1:0]     alu_c_i,
    output logic                  flags_we_o,
    input  logic                  flag_z_i,
    input  logic                  flag_c_i,
    output logic                  stk_push_o,
    output logic                  stk_pop_o,
    output logic [DATA_W-1:0]     stk_wdata_o,
    input  logic [DATA_W-1:0]     stk_rdata_i,
    input  logic                  stk_full_i,
    input  logic                  stk_empty_i,
    output logic                  pcs_push_o,
    output logic                  pcs_pop_o,
    output logic [PC_W-1:0]       pcs_wdata_o,
    input  logic [PC_W-1:0]       pcs_rdata_i,
    input  logic                  pcs_full_i,
    input  logic                  pcs_empty_i,
    output logic                  ram_re_o,
    input  logic                  ram_ack_i,
    input  logic [DATA_W-1:0]     ram_rdata_i,
    output logic                  ram_we_o,
    output logic [DATA_W-1:0]     ram_wdata_o,
    output logic                  int_clr_o,
    output logic                  fault_o
);

    state_e              state_q, state_d;
    logic [REG_AW-1:0]   rd_addr_q, rd_addr_d;
    logic                fault_q, fault_d;

    logic [7:0]          opcode;
    logic [DATA_W-1:0]   arg_a;
    logic [DATA_W-1:0]   arg_b;
    logic [REG_AW-1:0]   dst_addr;
    logic [REG_AW-1:0]   src_addr;
    logic [PC_W-1:0]     jump_target;
    logic [PC_W-1:0]     pc_next;
    logic                accept;
    logic                cond_take;
    logic                fault_hit;
    logic                unused_sig;

    assign opcode      = instr_i[8+2*DATA_W-1 -: 8];
    assign arg_a       = instr_i[2*DATA_W-1 -: DATA_W];
    assign arg_b       = instr_i[DATA_W-1:0];
    assign dst_addr    = arg_a[REG_AW-1:0];
    assign src_addr    = arg_b[REG_AW-1:0];
    assign jump_target = {arg_a[PC_W-DATA_W-1:0], arg_b};
    assign pc_next     = pc_i + PC_W'(1);

    dec_cond_eval u_cond (
        .opcode_i (opcode),
        .flag_z_i (flag_z_i),
        .flag_c_i (flag_c_i),
        .take_o   (cond_take)
    );

`ifdef DECODER_SEQ_FAULT_EN
    // Any of these would corrupt a stack or execute garbage, so the core halts instead.
    assign fault_hit = ((opcode == OP_PSH) && stk_full_i)
                     | ((opcode == OP_POP) && stk_empty_i)
                     | ((opcode == OP_CAL) && pcs_full_i)
                     | ((opcode == OP_RTN) && pcs_empty_i)
                     | ~is_known_op(opcode);
    assign unused_sig = ^arg_a;
`else
    assign fault_hit  = 1'b0;
    assign unused_sig = ^{arg_a, stk_full_i, stk_empty_i, pcs_full_i, pcs_empty_i};
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_RUN;
            rd_addr_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            fault_q   <= fault_d;
        end
    end

    assign fault_o = fault_q;

    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        fault_d       = fault_q;
        instr_ready_o = (state_q == ST_RUN) && rst_n_i;
        accept        = instr_valid_i && instr_ready_o;
        jump_en_o     = 1'b0;
        jump_addr_o   = '0;
        reg_we_o      = 1'b0;
        reg_waddr_o   = '0;
        reg_wdata_o   = '0;
        reg_raddr_a_o = '0;
        reg_raddr_b_o = '0;
        alu_op_o      = '0;
        alu_a_o       = '0;
        alu_b_o       = '0;
        flags_we_o    = 1'b0;
        stk_push_o    = 1'b0;
        stk_pop_o     = 1'b0;
        stk_wdata_o   = '0;
        pcs_push_o    = 1'b0;
        pcs_pop_o     = 1'b0;
        pcs_wdata_o   = '0;
        ram_re_o      = 1'b0;
        ram_we_o      = 1'b0;
        ram_wdata_o   = '0;
        int_clr_o     = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (accept && fault_hit) begin
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                end else if (accept) begin
                    reg_raddr_a_o = dst_addr;
                    reg_raddr_b_o = src_addr;
                    case (opcode)
                        OP_LD: begin
                            reg_we_o    = 1'b1;
                            reg_waddr_o = dst_addr;
                            reg_wdata_o = reg_rdata_b_i;
                        end
                        OP_LDR: begin
                            reg_we_o    = 1'b1;
                            reg_waddr_o = dst_addr;
                            reg_wdata_o = arg_b;
                        end
                        OP_ADD, OP_SUB, OP_INC, OP_DEC,
                        OP_AND, OP_OR, OP_XOR, OP_XNR: begin
                            alu_op_o    = alu_op_of(opcode);
                            alu_a_o     = reg_rdata_a_i;
                            alu_b_o     = reg_rdata_b_i;
                            flags_we_o  = 1'b1;
                            reg_we_o    = 1'b1;
                            reg_waddr_o = dst_addr;
                            reg_wdata_o = alu_c_i;
                        end
                        OP_COM: begin
                            alu_op_o   = ALU_SUB;
                            alu_a_o    = reg_rdata_a_i;
                            alu_b_o    = reg_rdata_b_i;
                            flags_we_o = 1'b1;
                        end
                        OP_CLR: begin
                            reg_we_o    = 1'b1;
                            reg_waddr_o = dst_addr;
                            reg_wdata_o = '0;
                        end
                        OP_FIL: begin
                            reg_we_o    = 1'b1;
                            reg_waddr_o = dst_addr;
                            reg_wdata_o = '1;
                        end
                        OP_PSH: begin
                            stk_push_o  = 1'b1;
                            stk_wdata_o = reg_rdata_a_i;
                        end
                        OP_POP: begin
                            stk_pop_o   = 1'b1;
                            reg_we_o    = 1'b1;
                            reg_waddr_o = dst_addr;
                            reg_wdata_o = stk_rdata_i;
                        end
                        OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC: begin
                            jump_en_o   = cond_take;
                            jump_addr_o = jump_target;
                        end
                        OP_CAL: begin
                            pcs_push_o  = 1'b1;
                            pcs_wdata_o = pc_next;
                            jump_en_o   = 1'b1;
                            jump_addr_o = jump_target;
                        end
                        OP_RTN: begin
                            pcs_pop_o   = 1'b1;
                            jump_en_o   = 1'b1;
                            jump_addr_o = pcs_rdata_i;
                        end
                        OP_WR: begin
                            ram_we_o    = 1'b1;
                            ram_wdata_o = reg_rdata_a_i;
                        end
                        OP_RD: begin
                            ram_re_o  = 1'b1;
                            rd_addr_d = dst_addr;
                            if (ram_ack_i) begin
                                reg_we_o    = 1'b1;
                                reg_waddr_o = dst_addr;
                                reg_wdata_o = ram_rdata_i;
                            end else begin
                                state_d = ST_RD_WAIT;
                            end
                        end
                        OP_CIS: int_clr_o = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_RD_WAIT: begin
                // Request stays up until the edge; a reset in flight abandons the write.
                ram_re_o = 1'b1;
                if (ram_ack_i && rst_n_i) begin
                    reg_we_o    = 1'b1;
                    reg_waddr_o = rd_addr_q;
                    reg_wdata_o = ram_rdata_i;
                    state_d     = ST_RUN;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq: stimulus pushes expected per-cycle
// outputs, a negedge monitor pops and compares them.
module tb_decoder_seq;
    import decoder_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid, instr_ready;
    logic [23:0] instr;
    logic [10:0] pc;
    logic        jump_en;
    logic [10:0] jump_addr;
    logic        reg_we;
    logic [5:0]  reg_waddr, reg_raddr_a, reg_raddr_b;
    logic [7:0]  reg_wdata, reg_rdata_a, reg_rdata_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a, alu_b, alu_c;
    logic        flags_we, flag_z, flag_c;
    logic        stk_push, stk_pop, stk_full, stk_empty;
    logic [7:0]  stk_wdata, stk_rdata;
    logic        pcs_push, pcs_pop, pcs_full, pcs_empty;
    logic [10:0] pcs_wdata, pcs_rdata;
    logic        ram_re, ram_ack, ram_we, int_clr, fault;
    logic [7:0]  ram_rdata, ram_wdata;

    always #5 clk = ~clk;

    decoder_seq dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .instr_i(instr), .pc_i(pc),
        .jump_en_o(jump_en), .jump_addr_o(jump_addr),
        .reg_we_o(reg_we), .reg_waddr_o(reg_waddr), .reg_wdata_o(reg_wdata),
        .reg_raddr_a_o(reg_raddr_a), .reg_raddr_b_o(reg_raddr_b),
        .reg_rdata_a_i(reg_rdata_a), .reg_rdata_b_i(reg_rdata_b),
        .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_c_i(alu_c),
        .flags_we_o(flags_we), .flag_z_i(flag_z), .flag_c_i(flag_c),
        .stk_push_o(stk_push), .stk_pop_o(stk_pop), .stk_wdata_o(stk_wdata),
        .stk_rdata_i(stk_rdata), .stk_full_i(stk_full), .stk_empty_i(stk_empty),
        .pcs_push_o(pcs_push), .pcs_pop_o(pcs_pop), .pcs_wdata_o(pcs_wdata),
        .pcs_rdata_i(pcs_rdata), .pcs_full_i(pcs_full), .pcs_empty_i(pcs_empty),
        .ram_re_o(ram_re), .ram_ack_i(ram_ack), .ram_rdata_i(ram_rdata),
        .ram_we_o(ram_we), .ram_wdata_o(ram_wdata),
        .int_clr_o(int_clr), .fault_o(fault)
    );

    typedef struct packed {
        logic        rdy;
        logic        reg_we;
        logic [5:0]  waddr;
        logic [7:0]  wdata;
        logic        flags_we;
        logic [2:0]  alu_op;
        logic [7:0]  alu_a;
        logic [7:0]  alu_b;
        logic        jump_en;
        logic [10:0] jump_addr;
        logic        stk_push;
        logic        stk_pop;
        logic        pcs_push;
        logic        pcs_pop;
        logic [10:0] pcs_wdata;
        logic        ram_re;
        logic        ram_we;
        logic        int_clr;
        logic        fault;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [23:0] mk(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        return {op, a, b};
    endfunction

    function automatic exp_t idle(input logic rdy);
        exp_t e;
        e = '0;
        e.rdy = rdy;
        return e;
    endfunction

    function automatic exp_t wr(input logic [5:0] a, input logic [7:0] d);
        exp_t e;
        e = idle(1'b1);
        e.reg_we = 1'b1;
        e.waddr  = a;
        e.wdata  = d;
        return e;
    endfunction

    task automatic cyc(input string nm, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t  e;
        exp_t  a;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = '0;
            a.rdy = instr_ready;   a.reg_we = reg_we;     a.waddr = reg_waddr;
            a.wdata = reg_wdata;   a.flags_we = flags_we; a.alu_op = alu_op;
            a.alu_a = alu_a;       a.alu_b = alu_b;       a.jump_en = jump_en;
            a.jump_addr = jump_addr; a.stk_push = stk_push; a.stk_pop = stk_pop;
            a.pcs_push = pcs_push; a.pcs_pop = pcs_pop;   a.pcs_wdata = pcs_wdata;
            a.ram_re = ram_re;     a.ram_we = ram_we;     a.int_clr = int_clr;
            a.fault = fault;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h", nm, a, e);
            end else begin
                $display("ok   %s: %h", nm, a);
            end
        end
    end

    initial begin
        exp_t e;
        logic [7:0] jops [4];
        logic       take;
        jops[0] = OP_JZ; jops[1] = OP_JNZ; jops[2] = OP_JC; jops[3] = OP_JNC;

        rst_n = 1'b0; instr_valid = 1'b1; instr = mk(OP_LDR, 8'h01, 8'h77); pc = '0;
        reg_rdata_a = '0; reg_rdata_b = '0; alu_c = '0; flag_z = 1'b0; flag_c = 1'b0;
        stk_rdata = '0; stk_full = 1'b0; stk_empty = 1'b0;
        pcs_rdata = '0; pcs_full = 1'b0; pcs_empty = 1'b0;
        ram_ack = 1'b0; ram_rdata = '0;
        @(posedge clk); #1;

        cyc("reset0", idle(1'b0));
        cyc("reset1", idle(1'b0));
        rst_n = 1'b1; instr_valid = 1'b0;
        cyc("ready_after_reset", idle(1'b1));

        instr_valid = 1'b1;
        instr = mk(OP_LDR, 8'h03, 8'h5A);
        cyc("ldr_r3", wr(6'd3, 8'h5A));
        instr = mk(OP_ADD, 8'h03, 8'h04); reg_rdata_a = 8'h5A; reg_rdata_b = 8'h10; alu_c = 8'h6A;
        e = wr(6'd3, 8'h6A); e.flags_we = 1'b1; e.alu_op = ALU_ADD; e.alu_a = 8'h5A; e.alu_b = 8'h10;
        cyc("add_r3_r4", e);
        instr = mk(OP_SUB, 8'h01, 8'h02); reg_rdata_a = 8'h20; reg_rdata_b = 8'h05; alu_c = 8'h1B;
        e = wr(6'd1, 8'h1B); e.flags_we = 1'b1; e.alu_op = ALU_SUB; e.alu_a = 8'h20; e.alu_b = 8'h05;
        cyc("sub_r1_r2", e);
        instr = mk(OP_COM, 8'h01, 8'h02); reg_rdata_a = 8'h10; reg_rdata_b = 8'h10; alu_c = 8'h00;
        e = idle(1'b1); e.flags_we = 1'b1; e.alu_op = ALU_SUB; e.alu_a = 8'h10; e.alu_b = 8'h10;
        cyc("com", e);
        instr = mk(OP_CLR, 8'h09, 8'h00);
        cyc("clr_r9", wr(6'd9, 8'h00));
        instr = mk(OP_FIL, 8'h0A, 8'h00);
        cyc("fil_r10", wr(6'd10, 8'hFF));
        instr = mk(OP_LD, 8'h05, 8'h06); reg_rdata_a = 8'h11; reg_rdata_b = 8'h77;
        cyc("ld_r5_r6", wr(6'd5, 8'h77));
        instr = mk(OP_PSH, 8'h02, 8'h00); reg_rdata_a = 8'h33;
        e = idle(1'b1); e.stk_push = 1'b1;
        cyc("psh", e);
        instr = mk(OP_POP, 8'h04, 8'h00); stk_rdata = 8'h44;
        e = wr(6'd4, 8'h44); e.stk_pop = 1'b1;
        cyc("pop", e);

        instr = mk(OP_CAL, 8'h01, 8'h23); pc = 11'h7FF;
        e = idle(1'b1); e.pcs_push = 1'b1; e.pcs_wdata = 11'h000; e.jump_en = 1'b1; e.jump_addr = 11'h123;
        cyc("cal_wrap", e);
        instr = mk(OP_RTN, 8'h00, 8'h00); pcs_rdata = 11'h000; pc = 11'h123;
        e = idle(1'b1); e.pcs_pop = 1'b1; e.jump_en = 1'b1; e.jump_addr = 11'h000;
        cyc("rtn_0", e);
        instr = mk(OP_RTN, 8'h00, 8'h00); pcs_rdata = 11'h3A5;
        e = idle(1'b1); e.pcs_pop = 1'b1; e.jump_en = 1'b1; e.jump_addr = 11'h3A5;
        cyc("rtn_3a5", e);
        instr = mk(OP_JMP, 8'h04, 8'h56);
        e = idle(1'b1); e.jump_en = 1'b1; e.jump_addr = 11'h456;
        cyc("jmp", e);

        for (int k = 0; k < 4; k++) begin
            for (int fzc = 0; fzc < 4; fzc++) begin
                flag_z = fzc[1]; flag_c = fzc[0];
                instr  = mk(jops[k], 8'hFA, 8'hAB);
                case (k)
                    0:       take = flag_z;
                    1:       take = ~flag_z;
                    2:       take = flag_c;
                    default: take = ~flag_c;
                endcase
                e = idle(1'b1); e.jump_en = take; e.jump_addr = 11'h2AB;
                cyc($sformatf("jcond_op%0d_z%0d_c%0d", k, flag_z, flag_c), e);
            end
        end
        flag_z = 1'b0; flag_c = 1'b0;

        instr = mk(OP_WR, 8'h02, 8'h00);
        e = idle(1'b1); e.ram_we = 1'b1;
        cyc("wr", e);
        instr = mk(OP_CIS, 8'h00, 8'h00);
        e = idle(1'b1); e.int_clr = 1'b1;
        cyc("cis", e);
        instr = mk(OP_NOP, 8'h12, 8'h34);
        cyc("nop", idle(1'b1));

        // RD with ack three cycles after accept; a queued LDR must wait
        instr = mk(OP_RD, 8'h07, 8'h00); ram_ack = 1'b0; ram_rdata = 8'h11;
        e = idle(1'b1); e.ram_re = 1'b1;
        cyc("rd_accept", e);
        instr = mk(OP_LDR, 8'h01, 8'h99);
        e = idle(1'b0); e.ram_re = 1'b1;
        cyc("rd_wait1", e);
        cyc("rd_wait2", e);
        ram_ack = 1'b1; ram_rdata = 8'hC3;
        e = idle(1'b0); e.ram_re = 1'b1; e.reg_we = 1'b1; e.waddr = 6'd7; e.wdata = 8'hC3;
        cyc("rd_complete", e);
        ram_ack = 1'b0;
        cyc("ldr_after_rd", wr(6'd1, 8'h99));

        instr = mk(OP_RD, 8'h07, 8'h00); ram_ack = 1'b1; ram_rdata = 8'h3C;
        e = wr(6'd7, 8'h3C); e.ram_re = 1'b1;
        cyc("rd_zero_wait", e);
        instr = mk(OP_NOP, 8'h00, 8'h00);
        cyc("ack_ignored", idle(1'b1));
        ram_ack = 1'b0;

        instr = mk(OP_RD, 8'h05, 8'h00);
        e = idle(1'b1); e.ram_re = 1'b1;
        cyc("rd_before_reset", e);
        rst_n = 1'b0; instr_valid = 1'b0; ram_ack = 1'b1; ram_rdata = 8'h55;
        e = idle(1'b0); e.ram_re = 1'b1;
        cyc("rd_reset_edge", e);
        cyc("rd_reset_after", idle(1'b0));
        rst_n = 1'b1; ram_ack = 1'b0;
        cyc("rd_reset_release", idle(1'b1));

        instr_valid = 1'b1;
        instr = mk(OP_POP, 8'h04, 8'h00); stk_empty = 1'b1; stk_rdata = 8'h66;
`ifdef DECODER_SEQ_FAULT_EN
        cyc("pop_empty_suppressed", idle(1'b1));
        stk_empty = 1'b0; instr = mk(OP_NOP, 8'h00, 8'h00);
        e = idle(1'b0); e.fault = 1'b1;
        cyc("halt1", e);
        cyc("halt2", e);
        rst_n = 1'b0;
        cyc("halt_reset", e);
        rst_n = 1'b1;
        cyc("halt_cleared", idle(1'b1));
        instr = mk(8'hEE, 8'h00, 8'h00);
        cyc("unknown_suppressed", idle(1'b1));
        instr = mk(OP_NOP, 8'h00, 8'h00);
        cyc("unknown_halt", e);
        rst_n = 1'b0;
        cyc("final_reset", e);
        rst_n = 1'b1;
`else
        e = wr(6'd4, 8'h66); e.stk_pop = 1'b1;
        cyc("pop_empty_issued", e);
        stk_empty = 1'b0;
        instr = mk(8'hEE, 8'h01, 8'h02);
        cyc("unknown_as_nop", idle(1'b1));
        instr = mk(OP_NOP, 8'h00, 8'h00);
        cyc("no_halt", idle(1'b1));
`endif
        instr_valid = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
